// File: rtl/axi_sram_if.sv
// AXI4 write/read channel bundle between an initiator and axi_sram_slave.
// Only the fields the scratchpad uses are carried. There are no ID, USER, LOCK, CACHE or QOS fields.
interface axi_sram_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    // Write address channel
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic [7:0]              awlen;
    logic [1:0]              awburst;
    logic [2:0]              awsize;
    logic                    awvalid;
    logic                    awready;
    // Write data channel
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wlast;
    logic                    wvalid;
    logic                    wready;
    // Write response channel
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    // Read address channel
    logic [ADDR_WIDTH-1:0]   araddr;
    logic [7:0]              arlen;
    logic [1:0]              arburst;
    logic [2:0]              arsize;
    logic                    arvalid;
    logic                    arready;
    // Read data channel
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rlast;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awlen, awburst, awsize, awvalid, input awready,
        output wdata, wstrb, wlast, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arlen, arburst, arsize, arvalid, input arready,
        input rdata, rresp, rlast, rvalid, output rready
    );

    modport slave (
        input awaddr, awlen, awburst, awsize, awvalid, output awready,
        input wdata, wstrb, wlast, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arlen, arburst, arsize, arvalid, output arready,
        output rdata, rresp, rlast, rvalid, input rready
    );
endinterface

// File: rtl/axi_sram_slave.sv
// AXI4 burst responder backed by a word-addressed on-chip memory.
// The write and read channels run independently, and each has its own FSM.
// Supported bursts: FIXED and INCR. WRAP and the reserved encoding are treated as INCR.
// Optional feature: define AXI_SRAM_BYTE_STROBE_EN to honour wstrb byte lanes.
// When it is undefined, every accepted beat writes the full word.
module axi_sram_slave #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH_WORDS = 1024
) (
    input  logic      clk,
    input  logic      reset,
    axi_sram_if.slave bus
);
    localparam int unsigned ByteLanes = DATA_WIDTH / 8;
    localparam int unsigned OffBits   = $clog2(ByteLanes);
    // The spare top bit lets an INCR burst that runs off the end stay out of range.
    // It never wraps back to a low word.
    localparam int unsigned IdxW      = ADDR_WIDTH - OffBits + 1;
    localparam int unsigned MemAw     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [IdxW-1:0] DepthIdx = IdxW'(DEPTH_WORDS);

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_DATA = 2'd1;
    localparam logic [1:0] W_RESP = 2'd2;
    localparam logic       R_IDLE = 1'b0;
    localparam logic       R_DATA = 1'b1;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    // Write channel state
    logic [1:0]      w_state_q, w_state_d;
    logic [IdxW-1:0] w_idx_q, w_idx_d;
    logic [7:0]      w_cnt_q, w_cnt_d;
    logic            w_fixed_q, w_fixed_d;
    logic            w_err_q, w_err_d;
    logic            aw_ready, w_in_range, mem_we;

    // Read channel state
    logic            r_state_q, r_state_d;
    logic [IdxW-1:0] r_idx_q, r_idx_d;
    logic [7:0]      r_cnt_q, r_cnt_d;       // beats still to fetch, minus one
    logic            r_fixed_q, r_fixed_d;
    logic            r_pend_q, r_pend_d;     // at least one beat still to fetch
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [1:0]      rresp_q, rresp_d;
    logic            rlast_q, rlast_d;
    logic            rvalid_q, rvalid_d;
    logic            ar_ready, r_fetch, r_fetch_fixed, r_fetch_in_range;
    logic [IdxW-1:0] r_fetch_idx;
    logic [7:0]      r_fetch_cnt;
    logic [DATA_WIDTH-1:0] r_mem_word;

    // These bus fields are accepted but carry no meaning for full-width word beats.
    logic unused_bits;
    assign unused_bits = ^{bus.awsize, bus.arsize, bus.awaddr, bus.araddr, bus.wstrb};

    assign aw_ready   = (w_state_q == W_IDLE) && !reset;
    assign w_in_range = (w_idx_q < DepthIdx);
    assign mem_we     = (w_state_q == W_DATA) && bus.wvalid && w_in_range;

    // Write FSM next state: latch the burst, count the beats and flag errors.
    always_comb begin
        w_state_d = w_state_q;
        w_idx_d   = w_idx_q;
        w_cnt_d   = w_cnt_q;
        w_fixed_d = w_fixed_q;
        w_err_d   = w_err_q;
        case (w_state_q)
            W_IDLE: begin
                if (bus.awvalid && aw_ready) begin
                    w_idx_d   = IdxW'(bus.awaddr >> OffBits);
                    w_cnt_d   = bus.awlen;
                    w_fixed_d = (bus.awburst == 2'b00);
                    w_err_d   = 1'b0;
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (bus.wvalid) begin
                    if (!w_in_range || (bus.wlast != (w_cnt_q == 8'd0))) w_err_d = 1'b1;
                    if (w_cnt_q == 8'd0) begin
                        w_state_d = W_RESP;
                    end else begin
                        w_cnt_d = w_cnt_q - 8'd1;
                        if (!w_fixed_q) w_idx_d = w_idx_q + IdxW'(1);
                    end
                end
            end
            W_RESP: begin
                if (bus.bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read FSM next state. The first beat is fetched in the AR handshake cycle,
    // and each later beat is fetched once the output register is free.
    always_comb begin
        r_state_d     = r_state_q;
        r_idx_d       = r_idx_q;
        r_cnt_d       = r_cnt_q;
        r_fixed_d     = r_fixed_q;
        r_pend_d      = r_pend_q;
        rdata_d       = rdata_q;
        rresp_d       = rresp_q;
        rlast_d       = rlast_q;
        rvalid_d      = rvalid_q;
        r_fetch       = 1'b0;
        r_fetch_idx   = r_idx_q;
        r_fetch_cnt   = r_cnt_q;
        r_fetch_fixed = r_fixed_q;
        case (r_state_q)
            R_IDLE: begin
                if (bus.arvalid && ar_ready) begin
                    r_fetch       = 1'b1;
                    r_fetch_idx   = IdxW'(bus.araddr >> OffBits);
                    r_fetch_cnt   = bus.arlen;
                    r_fetch_fixed = (bus.arburst == 2'b00);
                    r_fixed_d     = r_fetch_fixed;
                    r_state_d     = R_DATA;
                end
            end
            R_DATA: begin
                if (rvalid_q && bus.rready) begin
                    rvalid_d = 1'b0;
                    rlast_d  = 1'b0;
                    if (rlast_q) r_state_d = R_IDLE;
                end
                if ((!rvalid_q || bus.rready) && r_pend_q) r_fetch = 1'b1;
            end
            default: r_state_d = R_IDLE;
        endcase
        if (r_fetch) begin
            rvalid_d = 1'b1;
            rlast_d  = (r_fetch_cnt == 8'd0);
            rdata_d  = r_fetch_in_range ? r_mem_word : '0;
            rresp_d  = r_fetch_in_range ? 2'b00 : 2'b10;
            r_pend_d = (r_fetch_cnt != 8'd0);
            r_cnt_d  = r_fetch_cnt - 8'd1;
            r_idx_d  = r_fetch_fixed ? r_fetch_idx : r_fetch_idx + IdxW'(1);
        end
    end

    assign ar_ready         = (r_state_q == R_IDLE) && !reset;
    assign r_fetch_in_range = (r_fetch_idx < DepthIdx);
    assign r_mem_word       = mem[r_fetch_idx[MemAw-1:0]];

    // Channel state registers; the memory array itself is never reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_state_q <= W_IDLE;
            w_idx_q   <= '0;
            w_cnt_q   <= '0;
            w_fixed_q <= 1'b0;
            w_err_q   <= 1'b0;
            r_state_q <= R_IDLE;
            r_idx_q   <= '0;
            r_cnt_q   <= '0;
            r_fixed_q <= 1'b0;
            r_pend_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
            rlast_q   <= 1'b0;
            rvalid_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_idx_q   <= w_idx_d;
            w_cnt_q   <= w_cnt_d;
            w_fixed_q <= w_fixed_d;
            w_err_q   <= w_err_d;
            r_state_q <= r_state_d;
            r_idx_q   <= r_idx_d;
            r_cnt_q   <= r_cnt_d;
            r_fixed_q <= r_fixed_d;
            r_pend_q  <= r_pend_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rlast_q   <= rlast_d;
            rvalid_q  <= rvalid_d;
        end
    end

    // Memory write port. A read of the same word in the same cycle sees the old data.
    always_ff @(posedge clk) begin
        if (mem_we) begin
`ifdef AXI_SRAM_BYTE_STROBE_EN
            for (int unsigned i = 0; i < ByteLanes; i++) begin
                if (bus.wstrb[i]) mem[w_idx_q[MemAw-1:0]][i*8 +: 8] <= bus.wdata[i*8 +: 8];
            end
`else
            mem[w_idx_q[MemAw-1:0]] <= bus.wdata;
`endif
        end
    end

    assign bus.awready = aw_ready;
    assign bus.wready  = (w_state_q == W_DATA);
    assign bus.bvalid  = (w_state_q == W_RESP);
    assign bus.bresp   = w_err_q ? 2'b10 : 2'b00;
    assign bus.arready = ar_ready;
    assign bus.rdata   = rdata_q;
    assign bus.rresp   = rresp_q;
    assign bus.rlast   = rlast_q;
    assign bus.rvalid  = rvalid_q;
endmodule
